// File: rtl/vx_l2_req_arb.sv
// L1 -> L2 request arbiter and L2 -> L1 response demux.
// Requests: round-robin grant, source index appended to the tag LSBs, 2-entry output FIFO.
// Responses: 1-entry pipe register, steered to the L1 named by the tag LSBs.
module vx_l2_req_arb #(
    parameter int unsigned NUM_REQS      = 5,
    parameter int unsigned ADDR_WIDTH    = 26,
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned TAG_IN_WIDTH  = 12,
    localparam int unsigned SEL_BITS      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
    localparam int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQS-1:0]                    req_in_valid,
    input  logic [NUM_REQS-1:0]                    req_in_rw,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]         req_in_addr,
    input  logic [NUM_REQS*(DATA_WIDTH/8)-1:0]     req_in_byteen,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]         req_in_data,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]       req_in_tag,
    output logic [NUM_REQS-1:0]                    req_in_ready,
    output logic                                   req_out_valid,
    output logic                                   req_out_rw,
    output logic [ADDR_WIDTH-1:0]                  req_out_addr,
    output logic [DATA_WIDTH/8-1:0]                req_out_byteen,
    output logic [DATA_WIDTH-1:0]                  req_out_data,
    output logic [TAG_OUT_WIDTH-1:0]               req_out_tag,
    input  logic                                   req_out_ready,
    input  logic                                   rsp_in_valid,
    input  logic [DATA_WIDTH-1:0]                  rsp_in_data,
    input  logic [TAG_OUT_WIDTH-1:0]               rsp_in_tag,
    output logic                                   rsp_in_ready,
    output logic [NUM_REQS-1:0]                    rsp_out_valid,
    output logic [DATA_WIDTH-1:0]                  rsp_out_data,
    output logic [TAG_IN_WIDTH-1:0]                rsp_out_tag,
    input  logic [NUM_REQS-1:0]                    rsp_out_ready
);

    // Index registers keep at least one bit so the single-requester build still elaborates.
    localparam int unsigned SEL_W    = (SEL_BITS > 0) ? SEL_BITS : 1;
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ENTRY_W  = 1 + ADDR_WIDTH + BE_WIDTH + DATA_WIDTH + TAG_OUT_WIDTH;

    // ---------------- request path ----------------
    logic [SEL_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]        grant_idx;
    logic                    grant_found;
    logic [1:0]              count_q, count_d;
    logic                    wr_ptr_q, rd_ptr_q;
    logic [ENTRY_W-1:0]      mem_q [2];
    logic [ENTRY_W-1:0]      push_entry;
    logic [TAG_IN_WIDTH-1:0] sel_tag;
    logic [TAG_OUT_WIDTH-1:0] push_tag;
    logic                    can_push, push, pop;

    // Pick the first valid requester at or after rr_ptr, wrapping modulo NUM_REQS.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            idx = {{(32-SEL_W){1'b0}}, rr_ptr_q} + k;
            if (idx >= NUM_REQS) idx = idx - NUM_REQS;
            if (!grant_found && req_in_valid[idx[SEL_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[SEL_W-1:0];
            end
        end
    end

    assign can_push = (count_q != 2'd2);
    assign push     = grant_found && can_push && !reset;
    assign pop      = req_out_valid && req_out_ready;
    assign sel_tag  = req_in_tag[grant_idx*TAG_IN_WIDTH +: TAG_IN_WIDTH];

    if (SEL_BITS == 0) begin : g_tag_pass
        assign push_tag = sel_tag;
    end else begin : g_tag_append
        assign push_tag = {sel_tag, grant_idx};
    end

    assign push_entry = {req_in_rw[grant_idx],
                         req_in_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH],
                         req_in_byteen[grant_idx*BE_WIDTH +: BE_WIDTH],
                         req_in_data[grant_idx*DATA_WIDTH +: DATA_WIDTH],
                         push_tag};

    // Ready goes only to the granted requester, and only while the FIFO has room.
    always_comb begin
        req_in_ready = '0;
        if (push) req_in_ready[grant_idx] = 1'b1;
    end

    // Next-state for the round-robin pointer and FIFO occupancy.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Request FIFO storage and arbitration state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign req_out_valid = (count_q != 2'd0);
    assign {req_out_rw, req_out_addr, req_out_byteen, req_out_data, req_out_tag} =
        mem_q[rd_ptr_q];

    // ---------------- response path ----------------
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic [TAG_IN_WIDTH-1:0] rsp_tag_q;
    logic [SEL_W-1:0]        rsp_sel_q, rsp_sel_in;

    if (SEL_BITS == 0) begin : g_sel_none
        assign rsp_sel_in = '0;
    end else begin : g_sel_tag
        assign rsp_sel_in = rsp_in_tag[SEL_BITS-1:0];
        sel_legal: assert property (@(posedge clk) disable iff (reset)
            rsp_in_valid |-> ({{(32-SEL_W){1'b0}}, rsp_sel_in} < NUM_REQS));
    end

    // One-hot steer of the held response; a stalled target blocks the whole port.
    always_comb begin
        rsp_out_valid = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            rsp_out_valid[i] = rsp_valid_q && (rsp_sel_q == SEL_W'(i));
        end
        rsp_in_ready = !rsp_valid_q || |(rsp_out_valid & rsp_out_ready);
    end

    // Response pipe register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_sel_q   <= '0;
        end else if (rsp_in_ready) begin
            rsp_valid_q <= rsp_in_valid;
            if (rsp_in_valid) begin
                rsp_data_q <= rsp_in_data;
                rsp_tag_q  <= rsp_in_tag[TAG_OUT_WIDTH-1:SEL_BITS];
                rsp_sel_q  <= rsp_sel_in;
            end
        end
    end

    assign rsp_out_data = rsp_data_q;
    assign rsp_out_tag  = rsp_tag_q;

endmodule

// File: tb/tb_vx_l2_req_arb.sv
// Bench for vx_l2_req_arb: a 5-requester instance and a 1-requester instance driven side by side,
// with a cycle model and request scoreboard providing every expected value.
module tb_vx_l2_req_arb;

    localparam int N   = 5;
    localparam int AW  = 26;
    localparam int DW  = 64;
    localparam int BW  = 8;
    localparam int TW  = 12;
    localparam int SB  = 3;
    localparam int TOW = TW + SB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 5-requester instance
    logic [N-1:0]    req_in_valid, req_in_rw, req_in_ready;
    logic [N*AW-1:0] req_in_addr;
    logic [N*BW-1:0] req_in_byteen;
    logic [N*DW-1:0] req_in_data;
    logic [N*TW-1:0] req_in_tag;
    logic            req_out_valid, req_out_rw, req_out_ready;
    logic [AW-1:0]   req_out_addr;
    logic [BW-1:0]   req_out_byteen;
    logic [DW-1:0]   req_out_data;
    logic [TOW-1:0]  req_out_tag;
    logic            rsp_in_valid, rsp_in_ready;
    logic [DW-1:0]   rsp_in_data, rsp_out_data;
    logic [TOW-1:0]  rsp_in_tag;
    logic [N-1:0]    rsp_out_valid, rsp_out_ready;
    logic [TW-1:0]   rsp_out_tag;

    vx_l2_req_arb #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)) u_dut (
        .clk(clk), .reset(reset),
        .req_in_valid(req_in_valid), .req_in_rw(req_in_rw), .req_in_addr(req_in_addr),
        .req_in_byteen(req_in_byteen), .req_in_data(req_in_data), .req_in_tag(req_in_tag),
        .req_in_ready(req_in_ready),
        .req_out_valid(req_out_valid), .req_out_rw(req_out_rw), .req_out_addr(req_out_addr),
        .req_out_byteen(req_out_byteen), .req_out_data(req_out_data), .req_out_tag(req_out_tag),
        .req_out_ready(req_out_ready),
        .rsp_in_valid(rsp_in_valid), .rsp_in_data(rsp_in_data), .rsp_in_tag(rsp_in_tag),
        .rsp_in_ready(rsp_in_ready),
        .rsp_out_valid(rsp_out_valid), .rsp_out_data(rsp_out_data), .rsp_out_tag(rsp_out_tag),
        .rsp_out_ready(rsp_out_ready)
    );

    // 1-requester instance
    logic [0:0]    req_in_valid1, req_in_rw1, req_in_ready1;
    logic [AW-1:0] req_in_addr1, req_out_addr1;
    logic [BW-1:0] req_in_byteen1, req_out_byteen1;
    logic [DW-1:0] req_in_data1, req_out_data1, rsp_in_data1, rsp_out_data1;
    logic [TW-1:0] req_in_tag1, req_out_tag1, rsp_in_tag1, rsp_out_tag1;
    logic          req_out_valid1, req_out_rw1, req_out_ready1, rsp_in_valid1, rsp_in_ready1;
    logic [0:0]    rsp_out_valid1, rsp_out_ready1;

    vx_l2_req_arb #(.NUM_REQS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_in_valid(req_in_valid1), .req_in_rw(req_in_rw1), .req_in_addr(req_in_addr1),
        .req_in_byteen(req_in_byteen1), .req_in_data(req_in_data1), .req_in_tag(req_in_tag1),
        .req_in_ready(req_in_ready1),
        .req_out_valid(req_out_valid1), .req_out_rw(req_out_rw1), .req_out_addr(req_out_addr1),
        .req_out_byteen(req_out_byteen1), .req_out_data(req_out_data1),
        .req_out_tag(req_out_tag1), .req_out_ready(req_out_ready1),
        .rsp_in_valid(rsp_in_valid1), .rsp_in_data(rsp_in_data1), .rsp_in_tag(rsp_in_tag1),
        .rsp_in_ready(rsp_in_ready1),
        .rsp_out_valid(rsp_out_valid1), .rsp_out_data(rsp_out_data1),
        .rsp_out_tag(rsp_out_tag1), .rsp_out_ready(rsp_out_ready1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Source-side state: per-requester pending count and current payload.
    bit            cur_rw [N];
    logic [AW-1:0] cur_addr [N];
    logic [BW-1:0] cur_be [N];
    logic [DW-1:0] cur_data [N];
    logic [TW-1:0] cur_tag [N];
    int            rem [N];
    logic [TOW+DW-1:0] rsp_src [$];

    bit            cur1_rw;
    logic [AW-1:0] cur1_addr;
    logic [BW-1:0] cur1_be;
    logic [DW-1:0] cur1_data;
    logic [TW-1:0] cur1_tag;
    int            rem1;
    logic [TW+DW-1:0] rsp_src1 [$];

    // Model state: scoreboard of expected L2 requests and the response pipe.
    logic [127:0]  mq [$];
    int            m_ptr;
    bit            m_rv;
    logic [DW-1:0] m_rdata;
    logic [TW-1:0] m_rtag;
    int            m_rsel;
    logic [127:0]  mq1 [$];
    bit            m1_rv;
    logic [DW-1:0] m1_rdata;
    logic [TW-1:0] m1_rtag;

    task automatic new_payload(input int i);
        cur_rw[i]   = 1'($urandom_range(0, 1));
        cur_addr[i] = AW'($urandom);
        cur_be[i]   = BW'($urandom);
        cur_data[i] = {$urandom, $urandom};
        cur_tag[i]  = TW'($urandom);
    endtask

    task automatic new_payload1();
        cur1_rw   = 1'($urandom_range(0, 1));
        cur1_addr = AW'($urandom);
        cur1_be   = BW'($urandom);
        cur1_data = {$urandom, $urandom};
        cur1_tag  = TW'($urandom);
    endtask

    function automatic int exp_grant();
        if (reset || mq.size() >= 2) return -1;
        for (int k = 0; k < N; k++) begin
            if (rem[(m_ptr + k) % N] > 0) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit exp_grant1();
        return !reset && rem1 > 0 && mq1.size() < 2;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_in_valid[i]           = rem[i] > 0;
            req_in_rw[i]              = cur_rw[i];
            req_in_addr[i*AW +: AW]   = cur_addr[i];
            req_in_byteen[i*BW +: BW] = cur_be[i];
            req_in_data[i*DW +: DW]   = cur_data[i];
            req_in_tag[i*TW +: TW]    = cur_tag[i];
        end
        rsp_in_valid = rsp_src.size() > 0;
        {rsp_in_tag, rsp_in_data} = (rsp_src.size() > 0) ? rsp_src[0] : '0;
        req_in_valid1  = rem1 > 0;
        req_in_rw1     = cur1_rw;
        req_in_addr1   = cur1_addr;
        req_in_byteen1 = cur1_be;
        req_in_data1   = cur1_data;
        req_in_tag1    = cur1_tag;
        rsp_in_valid1  = rsp_src1.size() > 0;
        {rsp_in_tag1, rsp_in_data1} = (rsp_src1.size() > 0) ? rsp_src1[0] : '0;
    endtask

    task automatic compare();
        int g;
        logic [N-1:0] er, ev;
        g  = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check_eq("req_in_ready", req_in_ready, er);
        check_eq("req_out_valid", req_out_valid, mq.size() != 0);
        if (mq.size() != 0)
            check_eq("req_out", {req_out_rw, req_out_addr, req_out_byteen, req_out_data,
                                 req_out_tag}, mq[0]);
        ev = '0;
        if (m_rv) ev[m_rsel] = 1'b1;
        check_eq("rsp_in_ready", rsp_in_ready, !m_rv || rsp_out_ready[m_rsel]);
        check_eq("rsp_out_valid", rsp_out_valid, ev);
        if (m_rv) begin
            check_eq("rsp_out_data", rsp_out_data, m_rdata);
            check_eq("rsp_out_tag", rsp_out_tag, m_rtag);
        end
        check_eq("req_in_ready1", req_in_ready1, exp_grant1());
        check_eq("req_out_valid1", req_out_valid1, mq1.size() != 0);
        if (mq1.size() != 0)
            check_eq("req_out1", {req_out_rw1, req_out_addr1, req_out_byteen1, req_out_data1,
                                  req_out_tag1}, mq1[0]);
        check_eq("rsp_in_ready1", rsp_in_ready1, !m1_rv || rsp_out_ready1[0]);
        check_eq("rsp_out_valid1", rsp_out_valid1, m1_rv);
        if (m1_rv) begin
            check_eq("rsp_out_data1", rsp_out_data1, m1_rdata);
            check_eq("rsp_out_tag1", rsp_out_tag1, m1_rtag);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mq1.delete();
        m_ptr = 0;
        m_rv  = 1'b0;
        m1_rv = 1'b0;
    endtask

    // Advance the model across one rising edge, using the inputs the DUT sampled.
    task automatic update();
        int g;
        bit g1, rr, rr1;
        logic [TOW-1:0] t;
        if (reset) begin
            model_reset();
            return;
        end
        g   = exp_grant();
        g1  = exp_grant1();
        rr  = !m_rv || rsp_out_ready[m_rsel];
        rr1 = !m1_rv || rsp_out_ready1[0];
        if (req_out_ready && mq.size() != 0) void'(mq.pop_front());
        if (g >= 0) begin
            mq.push_back(128'({cur_rw[g], cur_addr[g], cur_be[g], cur_data[g], cur_tag[g],
                               SB'(g)}));
            m_ptr = (g + 1) % N;
            rem[g]--;
            new_payload(g);
        end
        if (rr) begin
            m_rv = rsp_src.size() > 0;
            if (m_rv) begin
                {t, m_rdata} = rsp_src.pop_front();
                m_rtag = t[TOW-1:SB];
                m_rsel = int'(t[SB-1:0]);
            end
        end
        if (req_out_ready1 && mq1.size() != 0) void'(mq1.pop_front());
        if (g1) begin
            mq1.push_back(128'({cur1_rw, cur1_addr, cur1_be, cur1_data, cur1_tag}));
            rem1--;
            new_payload1();
        end
        if (rr1) begin
            m1_rv = rsp_src1.size() > 0;
            if (m1_rv) {m1_rtag, m1_rdata} = rsp_src1.pop_front();
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            compare();
            @(posedge clk);
            update();
            #1;
            drive();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        req_out_ready  = 1'b0;
        rsp_out_ready  = '1;
        req_out_ready1 = 1'b0;
        rsp_out_ready1 = 1'b1;
        rem1 = 0;
        new_payload1();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            new_payload(i);
        end
        rem[2] = 1;
        model_reset();
        drive();

        // Reset state: outputs cleared, no ready while in reset.
        @(negedge clk);
        check_eq("rst_req_in_ready", req_in_ready, '0);
        check_eq("rst_req_out_valid", req_out_valid, 1'b0);
        check_eq("rst_req_out_tag", req_out_tag, '0);
        check_eq("rst_req_out_data", req_out_data, '0);
        check_eq("rst_rsp_out_valid", rsp_out_valid, '0);
        check_eq("rst_rsp_out_data", rsp_out_data, '0);
        check_eq("rst_rsp_out_tag", rsp_out_tag, '0);
        check_eq("rst_req_out_valid1", req_out_valid1, 1'b0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        rem[2] = 0;
        drive();
        step(2);

        // Round robin with all requesters valid and the L2 always ready.
        req_out_ready = 1'b1;
        for (int i = 0; i < N; i++) rem[i] = 7;
        drive();
        step(10);
        for (int i = 0; i < N; i++) rem[i] = 0;
        drive();
        step(3);

        // Tag append on requester 3 and the matching response.
        cur_tag[3] = 12'h0A5;
        rem[3] = 1;
        drive();
        step(1);
        #2;
        check_eq("tag_append", req_out_tag, {12'h0A5, 3'b011});
        rsp_src.push_back({12'h0A5, 3'd3, 64'h0123_4567_89AB_CDEF});
        drive();
        step(1);
        #2;
        check_eq("rsp_demux_valid", rsp_out_valid, 5'b01000);
        check_eq("rsp_demux_tag", rsp_out_tag, 12'h0A5);
        step(2);

        // Backpressure: three requesters, L2 not ready -> two accepted, then stall.
        req_out_ready = 1'b0;
        rem[0] = 1;
        rem[2] = 1;
        rem[4] = 1;
        drive();
        step(4);
        #2;
        check_eq("full_no_ready", req_in_ready, '0);
        req_out_ready = 1'b1;
        drive();
        step(5);

        // Response stall on index 1 while requests keep flowing.
        rsp_out_ready = 5'b11101;
        rsp_src.push_back({12'h111, 3'd1, 64'hAAAA_0000_0000_0001});
        rsp_src.push_back({12'h222, 3'd2, 64'hBBBB_0000_0000_0002});
        rem[1] = 3;
        drive();
        step(4);
        #2;
        check_eq("rsp_stall_ready", rsp_in_ready, 1'b0);
        rsp_out_ready = '1;
        drive();
        step(4);

        // Reset mid-operation with a full FIFO and a stalled response.
        req_out_ready = 1'b0;
        rem[0] = 2;
        rem[1] = 2;
        rsp_out_ready = 5'b11110;
        rsp_src.push_back({12'h333, 3'd0, 64'hCCCC_0000_0000_0003});
        drive();
        step(3);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_req_out_valid", req_out_valid, 1'b0);
        check_eq("mid_rst_rsp_out_valid", rsp_out_valid, '0);
        check_eq("mid_rst_req_in_ready", req_in_ready, '0);
        model_reset();
        for (int i = 0; i < N; i++) rem[i] = 0;
        rsp_src.delete();
        drive();
        step(2);
        reset = 1'b0;
        req_out_ready = 1'b1;
        rsp_out_ready = '1;
        for (int i = 0; i < N; i++) rem[i] = 1;
        drive();
        #2;
        check_eq("post_rst_grant0", req_in_ready, 5'b00001);
        step(8);

        // Single-requester build: back-to-back requests and responses.
        req_out_ready1 = 1'b1;
        rsp_out_ready1 = 1'b1;
        rem1 = 6;
        for (int i = 0; i < 6; i++) rsp_src1.push_back({TW'($urandom), $urandom, $urandom});
        drive();
        step(1);
        #2;
        check_eq("n1_first_out", req_out_valid1, 1'b1);
        step(9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_l2_req_arb.md
Name: vx_l2_req_arb

Overview:
- Shares the single L2 core-side port among the NUM_L1_OUTPUTS L1 memory streams: icache, dcache, and the optional tcache, rcache and ocache.
- Request path: round-robin arbitration, then the source index is appended to the L1 memory tag, then a 2-entry elastic output buffer.
- Response path: demultiplexes L2 responses back to the originating L1 using the tag LSBs, through a 1-entry pipe register.
- Sits between the L1 cache cluster outputs and the L2 cache input (L2_NUM_REQS = 1 after this block).

Parameters:
- NUM_REQS, 5, number of L1 requesters (2 + TEX + RASTER + ROP enables); must be at least 1.
- ADDR_WIDTH, 26, line address width (32 - log2(L1_BLOCK_SIZE)).
- DATA_WIDTH, 512, line data width (L1_BLOCK_SIZE*8).
- TAG_IN_WIDTH, 12, L1 memory tag width (L1_MEM_TAG_WIDTH).
- SEL_BITS, derived as CLOG2(NUM_REQS); 0 when NUM_REQS=1.
- TAG_OUT_WIDTH, derived as TAG_IN_WIDTH + SEL_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_in_valid  in  NUM_REQS  per-requester request valid.
- req_in_rw  in  NUM_REQS  1 = write.
- req_in_addr  in  NUM_REQS*ADDR_WIDTH  line address.
- req_in_byteen  in  NUM_REQS*(DATA_WIDTH/8)  write byte enables.
- req_in_data  in  NUM_REQS*DATA_WIDTH  write data.
- req_in_tag  in  NUM_REQS*TAG_IN_WIDTH  L1 tag.
- req_in_ready  out  NUM_REQS  accept for each requester.
- req_out_valid, req_out_rw, req_out_addr, req_out_byteen, req_out_data  out  (1, 1, ADDR_WIDTH, DATA_WIDTH/8, DATA_WIDTH)  request to L2.
- req_out_tag  out  TAG_OUT_WIDTH  {in_tag, src_idx}, src_idx in the LSBs.
- req_out_ready  in  1  L2 accept.
- rsp_in_valid  in  1  L2 response valid.
- rsp_in_data  in  DATA_WIDTH  response data.
- rsp_in_tag  in  TAG_OUT_WIDTH  response tag.
- rsp_in_ready  out  1  accept from L2.
- rsp_out_valid  out  NUM_REQS  response valid to each L1.
- rsp_out_data  out  DATA_WIDTH  response data, shared by all L1s.
- rsp_out_tag  out  TAG_IN_WIDTH  response tag with the index stripped, shared by all L1s.
- rsp_out_ready  in  NUM_REQS  per-L1 accept.

Behaviour:
- Reset (async assert, deassert synchronous to clk):
  - buffer count = 0; req_out_valid = 0.
  - rsp pipe empty; rsp_out_valid = 0.
  - rr_ptr = 0.
  - req_in_ready = 0 while reset is asserted.
  - All data/tag outputs = 0.
- Handshake: a transfer fires when valid && ready, sampled at the rising edge. Valid never depends on ready. Payload is held stable by the source while valid && !ready.
- Arbitration:
  - Each cycle, grant goes to the first i with req_in_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQS.
  - req_in_ready[i] = grant[i] && (count < 2). At most one requester is accepted per cycle.
  - On a fire by i, rr_ptr <= (i+1) mod NUM_REQS. With no fire, rr_ptr holds.
  - rr_ptr wraps from NUM_REQS-1 to 0.
  - Starvation bound: a continuously valid requester is served within NUM_REQS fires.
- Request buffer:
  - 2-entry FIFO holding {rw, addr, byteen, data, in_tag, src_idx}.
  - req_out_valid = (count != 0).
  - Latency: accepted at edge N, visible on req_out at cycle N+1 (registered).
  - Simultaneous push and pop: count is unchanged and order is preserved.
  - Full (count=2): all req_in_ready = 0 and rr_ptr holds.
  - Sustained throughput: 1 request/cycle with req_out_ready=1.
- Tag encoding:
  - req_out_tag = {req_in_tag[i], i[SEL_BITS-1:0]}.
  - NUM_REQS=1: SEL_BITS=0, the tag passes through unchanged and the response goes always to index 0.
- Response path:
  - 1-entry pipe register {data, tag, sel}.
  - sel = rsp_in_tag[SEL_BITS-1:0]; rsp_out_tag = rsp_in_tag[TAG_OUT_WIDTH-1:SEL_BITS].
  - rsp_in_ready = !rsp_valid_r || rsp_out_ready[sel_r].
  - rsp_out_valid = one-hot(sel_r) & {NUM_REQS{rsp_valid_r}}.
  - Latency: 1 cycle. Sustained throughput: 1/cycle when the target is ready.
  - A stalled target blocks all responses (in-order L2 port; no bypass).
  - sel >= NUM_REQS is illegal; an assertion fires in simulation.
- Request and response paths are independent: a response stall does not block requests, and vice versa.
- Reset mid-operation: buffered requests and the pending response are discarded, with no output glitch beyond the async clear.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with 2 requests buffered -> req_out_valid=0 and rsp_out_valid=0 immediately; after release, rr_ptr=0.
- Round-robin, NUM_REQS=5, all 5 valid continuously, req_out_ready=1 -> grant order 0,1,2,3,4,0; one request out per cycle, starting 1 cycle after the first accept.
- Tag append: requester 3 sends tag 0x0A5 -> req_out_tag = {0x0A5, 3'b011}. A response with that tag gives rsp_out_valid=5'b01000 and rsp_out_tag=0x0A5, one cycle later.
- Backpressure: req_out_ready=0 with 3 requesters valid -> exactly 2 accepted, then all req_in_ready=0 and rr_ptr frozen. Release ready -> FIFO order preserved and the 3rd requester served next.
- Response stall: rsp_out_ready[1]=0 with a response for index 1 pending, followed by one for index 2 -> rsp_in_ready=0 until ready[1]=1; then index 2 is delivered on the next cycle.
- Degenerate config: NUM_REQS=1 -> tag unchanged; back-to-back requests and responses at full rate with 1-cycle latency each.
